// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha channel arbiter: FSM encoding, default
// state width and a constant-evaluable ceil-log2 helper.
package chacha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_e;

    localparam int STATE_W_DEFAULT = 512;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first set request found searching upward from the
// slot after last_grant, wrapping modulo NUM_CH.
module rr_arbiter
    import chacha_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int GW     = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
)(
    input  logic [NUM_CH-1:0] req,
    input  logic [GW-1:0]     last_grant,
    output logic [GW-1:0]     grant,
    output logic              any_req
);

    int          idx;
    logic [GW-1:0] cand;

    // Walk from the farthest slot back to the nearest so the nearest hit wins.
    always_comb begin
        grant = last_grant;
        idx   = 0;
        cand  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = GW'(idx);
            if (req[cand]) begin
                grant = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/chacha_channel_arbiter.sv
// Shares one ChaCha20 core among NUM_CH clients: latches requests, grants
// round-robin, returns the result to the granted channel, flags a hung core.
module chacha_channel_arbiter
    import chacha_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int STATE_W        = STATE_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_start,
    input  logic [NUM_CH-1:0]         ch_mode,
    input  logic [NUM_CH*STATE_W-1:0] ch_in_state,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic [NUM_CH-1:0]         ch_done,
    output logic                      ch_err,
    output logic [STATE_W-1:0]        ch_out_state,
    output logic                      core_start,
    output logic                      core_mode,
    output logic [STATE_W-1:0]        core_in_state,
    input  logic                      core_busy,
    input  logic                      core_done,
    input  logic [STATE_W-1:0]        core_out_state
);

    localparam int GW = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
    localparam int CW = (clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] LAST_RESET  = GW'(NUM_CH - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [STATE_W-1:0]  out_q, out_d;

    logic [NUM_CH-1:0]   mode_q;
    logic [STATE_W-1:0]  in_state_q [NUM_CH];

    logic [NUM_CH-1:0]   accept;
    logic [GW-1:0]       arb_grant;
    logic                arb_any;
    logic                issuing;

    assign accept = ch_start & ~pend_q;

    // Request payloads need no reset: they are only observed while pend is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                mode_q[i]     <= ch_mode[i];
                in_state_q[i] <= ch_in_state[i*STATE_W +: STATE_W];
            end
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req        (pend_q),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            grant_q      <= '0;
            last_grant_q <= LAST_RESET;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            out_q        <= out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q | accept;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        out_d        = out_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any && !core_busy) begin
                    grant_d = arb_grant;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A real completion wins over a timeout landing on the same cycle.
                if (core_done) begin
                    out_d   = core_out_state;
                    err_d   = 1'b0;
                    state_d = ST_DELIVER;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if ((TIMEOUT_CYCLES != 0) && (cnt_d == TIMEOUT_CNT)) begin
                        out_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_DELIVER;
                    end
                end
            end
            ST_DELIVER: begin
                pend_d[grant_q] = 1'b0;
                last_grant_d    = grant_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_done
        assign ch_done[gi] = (state_q == ST_DELIVER) && (grant_q == GW'(gi));
    end

    assign issuing       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign ch_busy       = pend_q;
    assign ch_err        = (state_q == ST_DELIVER) && err_q;
    assign ch_out_state  = out_q;
    assign core_start    = (state_q == ST_ISSUE);
    assign core_mode     = issuing && mode_q[grant_q];
    assign core_in_state = issuing ? in_state_q[grant_q] : '0;

endmodule

// File: tb/tb_chacha_channel_arbiter.sv
// Directed bench for chacha_channel_arbiter: a vector table of single-channel
// transactions plus hand-timed sequences for arbitration, watchdog and reset.
module tb_chacha_channel_arbiter;

    localparam int NCH = 4;
    localparam int SW  = 512;

    logic              clk = 1'b0;
    logic              rst;

    logic [NCH-1:0]    ch_start, ch_mode, ch_busy, ch_done;
    logic [NCH*SW-1:0] ch_in_state;
    logic              ch_err, core_start, core_mode, core_busy, core_done;
    logic [SW-1:0]     ch_out_state, core_in_state, core_out_state;

    logic [NCH-1:0]    t_ch_start, t_ch_mode, t_ch_busy, t_ch_done;
    logic [NCH*SW-1:0] t_ch_in_state;
    logic              t_ch_err, t_core_start, t_core_mode, t_core_busy, t_core_done;
    logic [SW-1:0]     t_ch_out_state, t_core_in_state, t_core_out_state;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chacha_channel_arbiter #(
        .NUM_CH(NCH), .STATE_W(SW), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_start(ch_start), .ch_mode(ch_mode), .ch_in_state(ch_in_state),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err), .ch_out_state(ch_out_state),
        .core_start(core_start), .core_mode(core_mode), .core_in_state(core_in_state),
        .core_busy(core_busy), .core_done(core_done), .core_out_state(core_out_state)
    );

    chacha_channel_arbiter #(
        .NUM_CH(NCH), .STATE_W(SW), .TIMEOUT_CYCLES(8)
    ) dut_to (
        .clk(clk), .rst(rst),
        .ch_start(t_ch_start), .ch_mode(t_ch_mode), .ch_in_state(t_ch_in_state),
        .ch_busy(t_ch_busy), .ch_done(t_ch_done), .ch_err(t_ch_err), .ch_out_state(t_ch_out_state),
        .core_start(t_core_start), .core_mode(t_core_mode), .core_in_state(t_core_in_state),
        .core_busy(t_core_busy), .core_done(t_core_done), .core_out_state(t_core_out_state)
    );

    typedef struct {
        int         ch;
        logic       mode;
        logic [7:0] in_b;
        logic [7:0] out_b;
        int         delay;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [SW-1:0] pat(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One complete request on the main instance; core_done arrives `delay`
    // cycles after the core_start cycle.
    task automatic run_txn(input int ch, input logic mode, input logic [7:0] in_b,
                           input logic [7:0] out_b, input int delay);
        logic [NCH-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        ch_start[ch] = 1'b1;
        ch_mode[ch]  = mode;
        ch_in_state[ch*SW +: SW] = pat(in_b);
        tick();
        ch_start = '0;
        chk_b("busy_rise", 32'(ch_busy), 32'(oh));
        chk_b("no_early_start", 32'(core_start), 32'd0);
        tick();
        chk_b("core_start", 32'(core_start), 32'd1);
        chk_b("core_mode", 32'(core_mode), 32'(mode));
        chk_w("core_in_state", core_in_state, pat(in_b));
        repeat (delay) tick();
        chk_b("no_early_done", 32'(ch_done), 32'd0);
        chk_w("in_state_held", core_in_state, pat(in_b));
        core_done      = 1'b1;
        core_out_state = pat(out_b);
        tick();
        core_done      = 1'b0;
        core_out_state = '0;
        chk_b("ch_done", 32'(ch_done), 32'(oh));
        chk_b("ch_err", 32'(ch_err), 32'd0);
        chk_w("ch_out_state", ch_out_state, pat(out_b));
        chk_b("busy_held", 32'(ch_busy), 32'(oh));
        tick();
        chk_b("done_clear", 32'(ch_done), 32'd0);
        chk_b("busy_fall", 32'(ch_busy), 32'd0);
        chk_w("out_hold", ch_out_state, pat(out_b));
        $display("txn ch=%0d mode=%0d in=%02h out=%02h delay=%0d", ch, mode, in_b, out_b, delay);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int found, g, cnt, starts;
        int exp_order [8];
        logic [NCH-1:0] oh;

        vecs[0] = '{ch: 2, mode: 1'b1, in_b: 8'hA5, out_b: 8'h5A, delay: 20};
        vecs[1] = '{ch: 0, mode: 1'b0, in_b: 8'h11, out_b: 8'hEE, delay: 1};
        vecs[2] = '{ch: 3, mode: 1'b1, in_b: 8'hFF, out_b: 8'h00, delay: 5};
        vecs[3] = '{ch: 1, mode: 1'b0, in_b: 8'h3C, out_b: 8'hC3, delay: 2};
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        ch_start = '0; ch_mode = '0; ch_in_state = '0;
        core_busy = 1'b0; core_done = 1'b0; core_out_state = '0;
        t_ch_start = '0; t_ch_mode = '0; t_ch_in_state = '0;
        t_core_busy = 1'b0; t_core_done = 1'b0; t_core_out_state = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk_b("rst_busy", 32'(ch_busy), 32'd0);
        chk_b("rst_done", 32'(ch_done), 32'd0);
        chk_b("rst_err", 32'(ch_err), 32'd0);
        chk_w("rst_out", ch_out_state, '0);
        chk_b("rst_core_start", 32'(core_start), 32'd0);
        chk_b("rst_core_mode", 32'(core_mode), 32'd0);
        chk_w("rst_core_in", core_in_state, '0);
        chk_b("rst_t_done", 32'(t_ch_done), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v].ch, vecs[v].mode, vecs[v].in_b, vecs[v].out_b, vecs[v].delay);
        end

        // Fairness: all channels request together after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_mode = 4'b0101;
        for (int c = 0; c < NCH; c++) ch_in_state[c*SW +: SW] = pat(8'h10 + 8'(c));
        ch_start = '1;
        tick();
        ch_start = '0;
        for (int k = 0; k < 8; k++) begin
            found = 0;
            for (int c = 0; c < 20 && found == 0; c++) begin
                if (core_start) found = 1;
                else tick();
            end
            chk_b("fair_start_seen", 32'(core_start), 32'd1);
            g = -1;
            for (int c = 0; c < NCH; c++) if (core_in_state == pat(8'h10 + 8'(c))) g = c;
            chk_b("fair_grant", 32'(g), 32'(exp_order[k]));
            chk_b("fair_mode", 32'(core_mode), 32'(ch_mode[exp_order[k]]));
            tick();
            core_done = 1'b1;
            core_out_state = pat(8'hC0 + 8'(k));
            tick();
            core_done = 1'b0;
            oh = '0;
            oh[exp_order[k]] = 1'b1;
            chk_b("fair_done", 32'(ch_done), 32'(oh));
            $display("txn fair k=%0d granted=%0d expected=%0d", k, g, exp_order[k]);
            tick();
            if (k < 4) begin
                ch_start[exp_order[k]] = 1'b1;
                tick();
                ch_start = '0;
            end
        end

        // Busy ignore: a second start while pending must not overwrite
        ch_mode[1] = 1'b0;
        ch_in_state[SW +: SW] = pat(8'h33);
        ch_start[1] = 1'b1;
        tick();
        chk_b("ign_busy", 32'(ch_busy), 32'h2);
        ch_mode[1] = 1'b1;
        ch_in_state[SW +: SW] = pat(8'h99);
        tick();
        ch_start = '0;
        chk_b("ign_core_start", 32'(core_start), 32'd1);
        chk_w("ign_core_in", core_in_state, pat(8'h33));
        chk_b("ign_core_mode", 32'(core_mode), 32'd0);
        ch_start[1] = 1'b1;
        tick();
        ch_start = '0;
        repeat (2) tick();
        chk_w("ign_core_in_wait", core_in_state, pat(8'h33));
        core_done = 1'b1;
        core_out_state = pat(8'h77);
        tick();
        core_done = 1'b0;
        cnt = 0;
        starts = 0;
        for (int c = 0; c < 15; c++) begin
            if (ch_done[1]) cnt++;
            if (core_start) starts++;
            tick();
        end
        chk_b("ign_done_count", 32'(cnt), 32'd1);
        chk_b("ign_no_reissue", 32'(starts), 32'd0);
        $display("txn busy-ignore dones=%0d reissues=%0d", cnt, starts);

        // Core busy gate
        core_busy = 1'b1;
        ch_mode[0] = 1'b0;
        ch_in_state[0 +: SW] = pat(8'h55);
        ch_start[0] = 1'b1;
        tick();
        ch_start = '0;
        starts = 0;
        for (int c = 0; c < 10; c++) begin
            if (core_start) starts++;
            tick();
        end
        chk_b("gate_no_start", 32'(starts), 32'd0);
        core_busy = 1'b0;
        chk_b("gate_fall_cycle", 32'(core_start), 32'd0);
        tick();
        chk_b("gate_start_after", 32'(core_start), 32'd1);
        chk_w("gate_core_in", core_in_state, pat(8'h55));
        tick();
        core_done = 1'b1;
        core_out_state = pat(8'h88);
        tick();
        core_done = 1'b0;
        chk_b("gate_done", 32'(ch_done), 32'h1);
        tick();
        $display("txn busy-gate ch=0 starts_while_busy=%0d", starts);

        // Watchdog instance: completion well before the limit
        t_ch_in_state[0 +: SW] = pat(8'h21);
        t_ch_start[0] = 1'b1;
        tick();
        t_ch_start = '0;
        tick();
        chk_b("t_core_start", 32'(t_core_start), 32'd1);
        repeat (3) tick();
        t_core_done = 1'b1;
        t_core_out_state = pat(8'h42);
        tick();
        t_core_done = 1'b0;
        chk_b("t_done", 32'(t_ch_done), 32'h1);
        chk_b("t_err", 32'(t_ch_err), 32'd0);
        chk_w("t_out", t_ch_out_state, pat(8'h42));
        tick();
        $display("txn watchdog-dut ch=0 normal");

        // core_done on the 8th WAIT cycle beats the timeout
        t_ch_in_state[SW +: SW] = pat(8'h22);
        t_ch_start[1] = 1'b1;
        tick();
        t_ch_start = '0;
        tick();
        chk_b("t_edge_start", 32'(t_core_start), 32'd1);
        repeat (8) tick();
        chk_b("t_edge_no_early", 32'(t_ch_done), 32'd0);
        t_core_done = 1'b1;
        t_core_out_state = pat(8'h43);
        tick();
        t_core_done = 1'b0;
        chk_b("t_edge_done", 32'(t_ch_done), 32'h2);
        chk_b("t_edge_err", 32'(t_ch_err), 32'd0);
        chk_w("t_edge_out", t_ch_out_state, pat(8'h43));
        tick();
        $display("txn watchdog-dut ch=1 done-at-limit");

        // Hung core: timeout after 8 WAIT cycles, next issue waits for core_busy
        t_ch_in_state[2*SW +: SW] = pat(8'h24);
        t_ch_start[2] = 1'b1;
        tick();
        t_ch_start = '0;
        tick();
        chk_b("t_to_start", 32'(t_core_start), 32'd1);
        t_core_busy = 1'b1;
        t_ch_in_state[3*SW +: SW] = pat(8'h25);
        t_ch_start[3] = 1'b1;
        tick();
        t_ch_start = '0;
        cnt = 0;
        for (int j = 1; j <= 8; j++) begin
            if (t_ch_done != '0) cnt++;
            tick();
        end
        chk_b("t_to_no_early", 32'(cnt), 32'd0);
        chk_b("t_to_done", 32'(t_ch_done), 32'h4);
        chk_b("t_to_err", 32'(t_ch_err), 32'd1);
        chk_w("t_to_out_zero", t_ch_out_state, '0);
        tick();
        chk_b("t_to_done_clear", 32'(t_ch_done), 32'd0);
        starts = 0;
        for (int c = 0; c < 5; c++) begin
            if (t_core_start) starts++;
            tick();
        end
        chk_b("t_to_hold_while_busy", 32'(starts), 32'd0);
        t_core_busy = 1'b0;
        chk_b("t_to_fall_cycle", 32'(t_core_start), 32'd0);
        tick();
        chk_b("t_to_reissue", 32'(t_core_start), 32'd1);
        chk_w("t_to_reissue_in", t_core_in_state, pat(8'h25));
        tick();
        t_core_done = 1'b1;
        t_core_out_state = pat(8'h52);
        tick();
        t_core_done = 1'b0;
        chk_b("t_after_done", 32'(t_ch_done), 32'h8);
        chk_b("t_after_err", 32'(t_ch_err), 32'd0);
        tick();
        $display("txn watchdog-dut ch=2 timeout, ch=3 reissued after core_busy fell");

        // Reset in the middle of WAIT
        ch_mode[1] = 1'b1;
        ch_in_state[SW +: SW] = pat(8'h61);
        ch_start[1] = 1'b1;
        tick();
        ch_start = '0;
        tick();
        chk_b("rw_start", 32'(core_start), 32'd1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_b("rw_busy", 32'(ch_busy), 32'd0);
        chk_b("rw_done", 32'(ch_done), 32'd0);
        chk_b("rw_err", 32'(ch_err), 32'd0);
        chk_w("rw_out", ch_out_state, '0);
        chk_b("rw_core_start", 32'(core_start), 32'd0);
        chk_b("rw_core_mode", 32'(core_mode), 32'd0);
        chk_w("rw_core_in", core_in_state, '0);
        core_done = 1'b1;
        core_out_state = pat(8'hEE);
        tick();
        core_done = 1'b0;
        core_out_state = '0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (ch_done != '0) cnt++;
            tick();
        end
        chk_b("rw_no_done", 32'(cnt), 32'd0);
        $display("txn reset-mid-wait stray_dones=%0d", cnt);
        run_txn(3, 1'b0, 8'h71, 8'h17, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
